// File: rtl/adder_arb_pkg.sv
// Shared types and sizing helpers for the adder_arbiter slice.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int OP_W_DEF    = 1;

  // Sum of two OP_W-bit operands needs one carry bit.
  function automatic int res_w(input int op_w);
    return op_w + 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester, response and shared-adder signals of adder_arbiter.
interface adder_arbiter_if #(
  parameter int NUM_REQ = adder_arb_pkg::NUM_REQ_DEF,
  parameter int OP_W    = adder_arb_pkg::OP_W_DEF
);
  localparam int RES_W = adder_arb_pkg::res_w(OP_W);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*OP_W-1:0] req_op1;
  logic [NUM_REQ*OP_W-1:0] req_op2;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [RES_W-1:0]        rsp_ans;
  logic [OP_W-1:0]         add_op1;
  logic [OP_W-1:0]         add_op2;
  logic [RES_W-1:0]        add_ans;

  // master: requesters plus the shared adder; slave: the arbiter itself
  modport master (
    output req_valid, req_op1, req_op2, add_ans,
    input  req_ready, rsp_valid, rsp_ans, add_op1, add_op2
  );

  modport slave (
    input  req_valid, req_op1, req_op2, add_ans,
    output req_ready, rsp_valid, rsp_ans, add_op1, add_op2
  );

endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker: first set req bit at or after ptr.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Time-shares one external adder among NUM_REQ valid/ready requesters.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int OP_W    = OP_W_DEF
) (
  input logic            clk,
  input logic            rst,
  adder_arbiter_if.slave bus
);

  localparam int RES_W = res_w(OP_W);
  localparam int IDX_W = idx_w(NUM_REQ);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt, arb_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic               accept;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;

  logic [IDX_W-1:0]   owner_p1;
  logic [OP_W-1:0]    op1_p1, op2_p1;
  logic [RES_W-1:0]   ans_p2;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  assign arb_ptr = ptr;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req (bus.req_valid),
    .ptr (arb_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign accept  = (state == IDLE) && gnt_any;
  assign ptr_nxt = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

  // Handshake outputs are masked while rst is high so no grant or
  // response is ever seen during reset, including mid-operation.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state)
      IDLE: begin
        if (gnt_any) begin
          state_nxt = ISSUE;
          if (!rst) req_ready = gnt;
        end
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        state_nxt = IDLE;
        if (!rst) rsp_valid[owner_p1] = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner_p1 <= '0;
      op1_p1   <= '0;
      op2_p1   <= '0;
      ans_p2   <= '0;
    end else begin
      state <= state_nxt;
      // p0 -> p1: capture the granted operands and owner on acceptance
      if (accept) begin
        op1_p1   <= bus.req_op1[gnt_idx*OP_W +: OP_W];
        op2_p1   <= bus.req_op2[gnt_idx*OP_W +: OP_W];
        owner_p1 <= gnt_idx;
`ifdef ADDER_ARB_FIXED_PRIO_EN
        ptr      <= '0;
`else
        ptr      <= ptr_nxt;
`endif
      end
      // p1 -> p2: adder has settled during ISSUE; its result is trusted as-is
      if (state == ISSUE) begin
        ans_p2 <= bus.add_ans;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_ans   = ans_p2;
  assign bus.add_op1   = op1_p1;
  assign bus.add_op2   = op2_p1;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: transaction-level model plus directed scenarios.
module tb_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 1;
  localparam int RW = W + 1;

  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } op_t;
  typedef struct { int due; int idx; int sum; } pend_t;
  typedef struct { int cyc; int idx; int mask; } glog_t;
  typedef struct { int cyc; int mask; int ans; } rlog_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]   drv_valid = '0;
  logic [N*W-1:0] drv_op1 = '0;
  logic [N*W-1:0] drv_op2 = '0;
  logic [N-1:0]   acc_mask = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  op_t   rq[N][$];
  pend_t pend[$];
  glog_t glog[$];
  rlog_t rlog[$];

  int m_ptr = 0;
  int m_idle_at = 0;
  int m_op1 = 0;
  int m_op2 = 0;
  int m_ans = 0;
  bit m_known = 1'b0;

  adder_arbiter_if #(.NUM_REQ(N), .OP_W(W)) bus ();

  adder_arbiter #(.NUM_REQ(N), .OP_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.req_valid = drv_valid;
  assign bus.req_op1   = drv_op1;
  assign bus.req_op2   = drv_op2;
  assign bus.add_ans   = RW'(bus.add_op1) + RW'(bus.add_op2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      drv_valid[i] = (rq[i].size() > 0);
      if (rq[i].size() > 0) begin
        drv_op1[i*W +: W] = rq[i][0].a;
        drv_op2[i*W +: W] = rq[i][0].b;
      end
    end
  endtask

  task automatic push(input int i, input int a, input int b);
    op_t o;
    o.a = W'(a);
    o.b = W'(b);
    rq[i].push_back(o);
  endtask

  // Requesters: drop the accepted request and present the next queued one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (acc_mask[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      refresh();
    end
  end

  // Model: a grant is possible from m_idle_at on; the result returns two cycles
  // after acceptance and the arbiter is free again three cycles after it.
  initial begin
    int g, j, mask;
    int exp_rdy, exp_rsp;
    forever begin
      @(negedge clk);
      cyc++;
      g = -1;
      if (!rst && cyc >= m_idle_at) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (g < 0 && drv_valid[j]) g = j;
        end
      end
      exp_rdy = (g >= 0) ? (1 << g) : 0;
      exp_rsp = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_ans = pend[0].sum;
        if (!rst) exp_rsp = 1 << pend[0].idx;
        void'(pend.pop_front());
      end

      chk("req_ready", 32'(bus.req_ready), exp_rdy);
      chk("rsp_valid", 32'(bus.rsp_valid), exp_rsp);
      if (m_known) begin
        chk("rsp_ans", 32'(bus.rsp_ans), m_ans);
        chk("add_op1", 32'(bus.add_op1), m_op1);
        chk("add_op2", 32'(bus.add_op2), m_op2);
      end

      if ((bus.req_ready & drv_valid) != '0) begin
        mask = int'(bus.req_ready);
        for (int i = 0; i < N; i++)
          if (mask[i]) glog.push_back('{cyc: cyc, idx: i, mask: mask});
      end
      if (bus.rsp_valid != '0)
        rlog.push_back('{cyc: cyc, mask: int'(bus.rsp_valid), ans: int'(bus.rsp_ans)});
      acc_mask = bus.req_ready & drv_valid;

      if (rst) begin
        m_ptr = 0;
        m_idle_at = cyc + 1;
        m_op1 = 0;
        m_op2 = 0;
        m_ans = 0;
        pend.delete();
        m_known = 1'b1;
      end else if (g >= 0) begin
        m_op1 = int'(drv_op1[g*W +: W]);
        m_op2 = int'(drv_op2[g*W +: W]);
        pend.push_back('{due: cyc + 2, idx: g, sum: m_op1 + m_op2});
        m_idle_at = cyc + 3;
`ifdef ADDER_ARB_FIXED_PRIO_EN
        m_ptr = 0;
`else
        m_ptr = (g + 1) % N;
`endif
      end
    end
  end

  task automatic wait_done(input string nm);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      #1;
      done = (pend.size() == 0);
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) done = 1'b0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout cyc=%0d got=busy want=idle", nm, cyc);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    int g0, r0;
    bit seen;
    int exp_ans[5];
    int exp_idx[4];

    // Reset with all four requesters already valid, then contention.
    for (int i = 0; i < N; i++) push(i, i % 2, 1);
    push(0, 0, 1);
    refresh();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_done("contend");
    exp_ans = '{1, 2, 1, 2, 1};
    chk("contend_ngrant", glog.size(), 5);
    chk("contend_nrsp", rlog.size(), 5);
    if (glog.size() >= 5 && rlog.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("contend_order", glog[i].idx, i % 4);
        chk("contend_ans", rlog[i].ans, exp_ans[i]);
      end
      for (int i = 0; i < 4; i++) chk("contend_gap", glog[i+1].cyc - glog[i].cyc, 3);
      chk("first_after_reset", glog[0].mask, 32'h1);
    end

    // Single request from requester 2.
    g0 = glog.size();
    r0 = rlog.size();
    push(2, 1, 1);
    refresh();
    wait_done("single");
    chk("single_ngrant", glog.size() - g0, 1);
    chk("single_nrsp", rlog.size() - r0, 1);
    if (glog.size() > g0 && rlog.size() > r0) begin
      chk("single_ready", glog[g0].mask, 32'h4);
      chk("single_rspmask", rlog[r0].mask, 32'h4);
      chk("single_ans", rlog[r0].ans, 2);
      chk("single_latency", rlog[r0].cyc - glog[g0].cyc, 2);
    end

    // All operand combinations on requester 0.
    r0 = rlog.size();
    push(0, 0, 0);
    push(0, 0, 1);
    push(0, 1, 0);
    push(0, 1, 1);
    refresh();
    wait_done("exhaust");
    exp_ans = '{0, 1, 1, 2, 0};
    chk("exhaust_nrsp", rlog.size() - r0, 4);
    if (rlog.size() - r0 >= 4)
      for (int i = 0; i < 4; i++) chk("exhaust_ans", rlog[r0+i].ans, exp_ans[i]);

    // Reset during ISSUE drops the operation.
    g0 = glog.size();
    r0 = rlog.size();
    push(1, 1, 1);
    refresh();
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      #1;
      seen = (glog.size() > g0);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midrst_grant_timeout cyc=%0d got=none want=grant", cyc);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    push(0, 1, 0);
    push(2, 0, 0);
    refresh();
    wait_done("midrst");
    chk("midrst_ngrant", glog.size() - g0, 3);
    chk("midrst_nrsp", rlog.size() - r0, 2);
    if (glog.size() - g0 >= 3 && rlog.size() - r0 >= 2) begin
      chk("midrst_next_grant", glog[g0+1].idx, 0);
      chk("midrst_rsp0", rlog[r0].mask, 32'h1);
      chk("midrst_rsp1", rlog[r0+1].mask, 32'h4);
    end

    // Requesters 0 and 3 together; previous grant was 2.
    g0 = glog.size();
    push(0, 1, 0);
    push(0, 1, 0);
    push(0, 1, 0);
    push(3, 0, 0);
    refresh();
    wait_done("prio");
`ifdef ADDER_ARB_FIXED_PRIO_EN
    exp_idx = '{0, 0, 0, 3};
`else
    exp_idx = '{3, 0, 0, 0};
`endif
    chk("prio_ngrant", glog.size() - g0, 4);
    if (glog.size() - g0 >= 4)
      for (int i = 0; i < 4; i++) chk("prio_order", glog[g0+i].idx, exp_idx[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
